piso32_tx: RTL and testbench
============================

PISO32_TX -- requirements
Module: piso32_tx

Interface
REQ-001 Parameter WIDTH, default 32: width of the parallel word.
REQ-002 Parameter MSB_FIRST, default 1: 1 = bit WIDTH-1 is sent first; 0 = bit 0 is sent first.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 i_valid  input  1  a parallel word is offered on i_data.
REQ-006 i_data  input  WIDTH  parallel word to serialize.
REQ-007 o_ready  output  1  block can accept a word this cycle.
REQ-008 o_sdata  output  1  serial data bit.
REQ-009 o_svalid  output  1  o_sdata carries a valid bit this cycle.
REQ-010 o_done  output  1  one-cycle pulse after the last bit of a word.

Function
REQ-011 The FSM SHALL have exactly three states: IDLE, SHIFT and DONE.
REQ-012 o_ready SHALL be 1 in IDLE only, and 0 in SHIFT and DONE.
REQ-013 A word SHALL be accepted on the rising edge where i_valid=1 and o_ready=1: i_data is captured into an internal WIDTH-bit shift register, the bit counter is cleared and the FSM moves IDLE->SHIFT.
REQ-014 i_valid while o_ready=0 SHALL be ignored, with no capture and no effect on the word in flight; the offering side holds i_valid until it sees o_ready.
REQ-015 Latency: the first serial bit SHALL appear on o_sdata with o_svalid=1 in the cycle immediately after the accepting edge.
REQ-016 In SHIFT, o_svalid SHALL be 1 for exactly WIDTH consecutive cycles, one bit per cycle, in the order set by MSB_FIRST.
REQ-017 The shift register SHALL shift by one position per cycle in SHIFT; the bit counter SHALL be $clog2(WIDTH) bits wide and increment by one per cycle.
REQ-018 When the counter equals WIDTH-1, the FSM SHALL move SHIFT->DONE at the next edge; the counter SHALL NOT wrap into a further bit.
REQ-019 DONE SHALL last exactly one cycle, with o_done=1, o_svalid=0 and o_ready=0, then move DONE->IDLE unconditionally.
REQ-020 Back-to-back words: a word offered during SHIFT or DONE SHALL be accepted in the first IDLE cycle, so the minimum spacing between first bits is WIDTH+2 cycles.
REQ-021 Whenever o_svalid=0, o_sdata SHALL be driven 0.
REQ-022 All outputs SHALL be registered or decoded from state only, with no combinational path from i_valid or i_data.

Reset
REQ-023 While reset=1, the FSM SHALL be IDLE, the shift register and counter 0, o_ready=1, o_sdata=0, o_svalid=0 and o_done=0, independent of clk.
REQ-024 A reset asserted mid-word SHALL abort the word immediately: no further bits are sent, and o_done is not pulsed.
REQ-025 After reset deasserts, the first rising edge with i_valid=1 SHALL be accepted normally.

Verification
REQ-026 Reset, then hold i_valid=0 for 5 cycles -> o_ready=1, o_svalid=0, o_sdata=0 and o_done=0 throughout.
REQ-027 MSB_FIRST=1, send 32'h38af_1297 -> o_svalid high for 32 cycles starting one cycle after acceptance; first 8 bits are 0,0,1,1,1,0,0,0 and last bit is 1; o_done pulses one cycle; o_ready returns 1 the cycle after the pulse.
REQ-028 MSB_FIRST=0, send 32'hcd0b_564e -> first 8 bits are 0,1,1,1,0,0,1,0; bit 32 is 1; o_done pulses once.
REQ-029 Offer 32'h0000_0000 and then hold 32'hffff_ffff with i_valid=1 continuously -> the first word gives 32 zero bits, DONE lasts one cycle, the second word is accepted in the following IDLE cycle and gives 32 one bits, and the first bit of the second word occurs 34 cycles after the first bit of the first word.
REQ-030 Change i_data while in SHIFT with i_valid=1 -> the serial stream is unchanged from the captured word.
REQ-031 Assert reset for 1 cycle after the 10th bit of 32'hdead_beef -> o_svalid drops immediately, o_done never pulses, o_ready=1; a following word is serialized correctly from its first bit.

Source files
------------

// File: rtl/piso32_tx.sv
// Parallel-in / serial-out transmitter: accepts one WIDTH-bit word in IDLE,
// streams it one bit per cycle in SHIFT, then pulses o_done for one DONE cycle.
module piso32_tx #(
  parameter int unsigned WIDTH     = 32,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_ready,
  output logic             o_sdata,
  output logic             o_svalid,
  output logic             o_done
);

  localparam int unsigned      CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  logic [1:0]       state_q,  state_d;
  logic [WIDTH-1:0] shreg_q,  shreg_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic             ready_q,  ready_d;
  logic             sdata_q,  sdata_d;
  logic             svalid_q, svalid_d;
  logic             done_q,   done_d;

  // State, datapath and output registers; reset leaves the block idle and ready.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      shreg_q  <= '0;
      cnt_q    <= '0;
      ready_q  <= 1'b1;
      sdata_q  <= 1'b0;
      svalid_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      cnt_q    <= cnt_d;
      ready_q  <= ready_d;
      sdata_q  <= sdata_d;
      svalid_q <= svalid_d;
      done_q   <= done_d;
    end
  end

  // Next state and datapath; outputs are derived from the next state so they
  // register in step with it and never see i_valid/i_data combinationally.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (i_valid) begin
          shreg_d = i_data;
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (cnt_q == CNT_LAST) begin
          state_d = ST_DONE;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
          shreg_d = MSB_FIRST ? (shreg_q << 1) : (shreg_q >> 1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    ready_d  = (state_d == ST_IDLE);
    svalid_d = (state_d == ST_SHIFT);
    done_d   = (state_d == ST_DONE);
    // The bit on the wire is always the leading end of the register.
    if (svalid_d) begin
      sdata_d = MSB_FIRST ? shreg_d[WIDTH-1] : shreg_d[0];
    end else begin
      sdata_d = 1'b0;
    end
  end

  assign o_ready  = ready_q;
  assign o_sdata  = sdata_q;
  assign o_svalid = svalid_q;
  assign o_done   = done_q;

endmodule

// File: tb/tb_piso32_tx.sv
// Bench for piso32_tx: one MSB-first and one LSB-first instance share stimulus;
// the expected serial streams are computed straight from the word's bit order.
module tb_piso32_tx;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         i_valid;
  logic [W-1:0] i_data;
  logic         rdy_m, sd_m, sv_m, dn_m;
  logic         rdy_l, sd_l, sv_l, dn_l;

  int unsigned n_chk    = 0;
  int unsigned n_err    = 0;
  int unsigned cyc      = 0;
  int unsigned done_cnt = 0;
  int unsigned bad_idle = 0;

  piso32_tx #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .reset(reset), .i_valid(i_valid), .i_data(i_data),
    .o_ready(rdy_m), .o_sdata(sd_m), .o_svalid(sv_m), .o_done(dn_m)
  );

  piso32_tx #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .reset(reset), .i_valid(i_valid), .i_data(i_data),
    .o_ready(rdy_l), .o_sdata(sd_l), .o_svalid(sv_l), .o_done(dn_l)
  );

  always #5 clk = ~clk;

  // Pre-edge sampling: count cycles, done pulses and stray data bits.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (dn_m) done_cnt <= done_cnt + 1;
    if ((!sv_m && sd_m) || (!sv_l && sd_l)) bad_idle <= bad_idle + 1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", tag, got, exp);
    end
  endtask

  // Offer a word from a falling edge and wait (bounded) for the accepting edge.
  task automatic offer(input logic [W-1:0] w, input bit hold, output int waited);
    bit r;
    bit ok;
    i_valid = 1'b1;
    i_data  = w;
    ok      = 1'b0;
    waited  = 0;
    while (!ok && waited < 200) begin
      r = rdy_m;
      @(posedge clk);
      waited++;
      if (r) ok = 1'b1;
      else @(negedge clk);
    end
    chk("accept_timeout", 64'(ok), 64'd1);
    #1;
    if (!hold) i_valid = 1'b0;
  endtask

  // Capture W bits after acceptance, then check the DONE cycle and return to IDLE.
  task automatic collect(input logic [W-1:0] w, input bit disturb,
                         output int unsigned first_cyc,
                         output logic [W-1:0] sm, output logic [W-1:0] sl);
    logic [W-1:0] em, el;
    int nvm, nvl;
    nvm = 0;
    nvl = 0;
    first_cyc = 0;
    for (int i = 0; i < W; i++) begin
      @(negedge clk);
      if (i == 0) first_cyc = cyc;
      sm[i] = sd_m;
      sl[i] = sd_l;
      nvm += int'(sv_m);
      nvl += int'(sv_l);
      em[i] = w[W-1-i];
      el[i] = w[i];
      if (disturb && i == 5) begin
        i_data  = $urandom;
        i_valid = 1'b1;
      end
    end
    chk("stream_msb", 64'(sm), 64'(em));
    chk("stream_lsb", 64'(sl), 64'(el));
    chk("nvalid_msb", 64'(nvm), 64'd32);
    chk("nvalid_lsb", 64'(nvl), 64'd32);
    @(negedge clk);
    chk("done_cycle", 64'({dn_m, sv_m, rdy_m, sd_m, dn_l, sv_l, rdy_l, sd_l}), 64'h88);
    @(negedge clk);
    chk("back_idle", 64'({dn_m, sv_m, rdy_m, sd_m, dn_l, sv_l, rdy_l, sd_l}), 64'h22);
    if (disturb) i_valid = 1'b0;
  endtask

  function automatic logic [7:0] first8(input logic [W-1:0] s);
    logic [7:0] f;
    f = '0;
    for (int i = 0; i < 8; i++) f = {f[6:0], s[i]};
    return f;
  endfunction

  initial begin
    int          waited;
    int unsigned fc1, fc2, d0, nsv;
    logic [W-1:0] sm, sl, w;
    logic [9:0]  part, pexp;

    reset   = 1'b0;
    i_valid = 1'b0;
    i_data  = '0;
    #1 reset = 1'b1;
    #2;
    chk("reset_async", 64'({rdy_m, sv_m, sd_m, dn_m, rdy_l, sv_l, sd_l, dn_l}), 64'h88);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Idle with no offers.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("idle_hold", 64'({rdy_m, sv_m, sd_m, dn_m, rdy_l, sv_l, sd_l, dn_l}), 64'h88);
    end

    // Known word, MSB-first order.
    d0 = done_cnt;
    offer(32'h38af_1297, 1'b0, waited);
    collect(32'h38af_1297, 1'b0, fc1, sm, sl);
    chk("msb_first8", 64'(first8(sm)), 64'b0011_1000);
    chk("msb_lastbit", 64'(sm[31]), 64'd1);
    chk("msb_done_once", 64'(done_cnt - d0), 64'd1);

    // Known word, LSB-first order.
    d0 = done_cnt;
    offer(32'hcd0b_564e, 1'b0, waited);
    collect(32'hcd0b_564e, 1'b0, fc1, sm, sl);
    chk("lsb_first8", 64'(first8(sl)), 64'b0111_0010);
    chk("lsb_bit32", 64'(sl[31]), 64'd1);
    chk("lsb_done_once", 64'(done_cnt - d0), 64'd1);

    // Back-to-back words with i_valid held high throughout.
    offer(32'h0000_0000, 1'b1, waited);
    i_data = 32'hffff_ffff;
    collect(32'h0000_0000, 1'b0, fc1, sm, sl);
    offer(32'hffff_ffff, 1'b0, waited);
    chk("b2b_accept_wait", 64'(waited), 64'd1);
    collect(32'hffff_ffff, 1'b0, fc2, sm, sl);
    chk("b2b_spacing", 64'(fc2 - fc1), 64'd34);

    // Input changes while shifting must not disturb the word in flight.
    w = $urandom;
    offer(w, 1'b0, waited);
    collect(w, 1'b1, fc1, sm, sl);

    // Reset after the 10th bit aborts the word.
    offer(32'hdead_beef, 1'b0, waited);
    w = 32'hdead_beef;
    part = '0;
    pexp = '0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      part[i] = sd_m;
      pexp[i] = w[W-1-i];
    end
    chk("abort_first10", 64'(part), 64'(pexp));
    d0 = done_cnt;
    reset = 1'b1;
    #1;
    chk("abort_outs", 64'({rdy_m, sv_m, sd_m, dn_m, rdy_l, sv_l, sd_l, dn_l}), 64'h88);
    @(negedge clk);
    reset = 1'b0;
    nsv = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      nsv += int'(sv_m) + int'(sv_l) + int'(!rdy_m);
    end
    chk("abort_quiet", 64'(nsv), 64'd0);
    chk("abort_no_done", 64'(done_cnt - d0), 64'd0);
    w = $urandom;
    offer(w, 1'b0, waited);
    chk("post_reset_accept", 64'(waited), 64'd1);
    collect(w, 1'b0, fc1, sm, sl);

    // Random words with random gaps.
    for (int k = 0; k < 4; k++) begin
      int gap;
      gap = int'($urandom_range(3, 0));
      for (int g = 0; g < gap; g++) @(negedge clk);
      w = $urandom;
      offer(w, 1'b0, waited);
      collect(w, 1'b0, fc1, sm, sl);
    end

    @(negedge clk);
    chk("sdata_zero_when_invalid", 64'(bad_idle), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
